// File: rtl/atm_ctrl_param_if.sv
// Front-end bundle between the card/keypad side and the ATM session controller.
interface atm_ctrl_param_if #(
    parameter int PIN_DIGITS = 4,
    parameter int DIG_W      = 4,
    parameter int BAL_W      = 64,
    parameter int AMT_W      = 32
) ();
    logic                        card_in;
    logic [PIN_DIGITS*DIG_W-1:0] card_pin;
    logic [BAL_W-1:0]            balance_in;
    logic [DIG_W-1:0]            digit;
    logic                        digit_stb;
    logic [AMT_W-1:0]            amount;
    logic                        amount_stb;
    logic                        trans_type;
    logic [BAL_W-1:0]            balance_out;
    logic                        balance_updated;
    logic                        dispense;
    logic                        insufficient_funds;
    logic                        limit_exceeded;
    logic                        deposit_overflow;
    logic                        pin_wrong;
    logic                        warning;
    logic                        lock_alarm;
    logic                        timeout;

    modport master (
        output card_in, card_pin, balance_in, digit, digit_stb, amount, amount_stb, trans_type,
        input  balance_out, balance_updated, dispense, insufficient_funds, limit_exceeded,
               deposit_overflow, pin_wrong, warning, lock_alarm, timeout
    );

    modport slave (
        input  card_in, card_pin, balance_in, digit, digit_stb, amount, amount_stb, trans_type,
        output balance_out, balance_updated, dispense, insufficient_funds, limit_exceeded,
               deposit_overflow, pin_wrong, warning, lock_alarm, timeout
    );
endinterface

// File: rtl/atm_ctrl_param.sv
// ATM session controller: PIN capture/verify with lockout, deposit/withdrawal with
// per-session withdrawal cap, inactivity timeout and registered status outputs.
//
// state   | meaning
// IDLE    | no session; waits for card (after a timeout, for a fresh insertion)
// PIN     | collecting PIN digits
// CHECK   | one-cycle PIN compare
// TRANS   | accepting deposit/withdrawal requests
// LOCK    | too many wrong PINs; only rst leaves
module atm_ctrl_param #(
    parameter int PIN_DIGITS = 4,
    parameter int DIG_W      = 4,
    parameter int BAL_W      = 64,
    parameter int AMT_W      = 32,
    parameter int MAX_TRIES  = 3,
    parameter int WD_LIMIT   = 2000,
    parameter int TIMEOUT    = 1000
) (
    input logic            clk,
    input logic            rst,
    atm_ctrl_param_if.slave bus
);
    localparam int PIN_W  = PIN_DIGITS * DIG_W;
    localparam int CNT_W  = $clog2(PIN_DIGITS + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int LIM_W  = $clog2(WD_LIMIT + 1);
    // Sum register must hold any in-limit total and never wrap when an amount is added.
    localparam int WD_W   = (AMT_W + 1 > LIM_W) ? AMT_W + 1 : LIM_W;

    typedef enum logic [2:0] {S_IDLE, S_PIN, S_CHECK, S_TRANS, S_LOCK} state_t;

    state_t            state_q, state_d;
    logic [PIN_W-1:0]  pin_q, pin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [BAL_W-1:0]  bal_q, bal_d;
    logic              rearm_q, rearm_d;
    logic              upd_q, upd_d, disp_q, disp_d, insuf_q, insuf_d, lim_q, lim_d;
    logic              ovf_q, ovf_d, pinw_q, pinw_d, warn_q, warn_d, lock_q, lock_d;
    logic              tmo_q, tmo_d;

    logic              end_sess;
    logic              any_stb;
    logic              idle_tc;
    logic [TRY_W-1:0]  tries_inc;
    logic [BAL_W:0]    dep_sum;
    logic [BAL_W-1:0]  amt_ext;
    logic [WD_W:0]     wd_sum;
    logic              wd_over;

    assign any_stb   = bus.digit_stb | bus.amount_stb;
    assign idle_tc   = (idle_q == IDLE_W'(TIMEOUT - 1));
    assign tries_inc = tries_q + 1'b1;
    assign amt_ext   = BAL_W'(bus.amount);
    assign dep_sum   = {1'b0, bal_q} + (BAL_W+1)'(bus.amount);
    assign wd_sum    = (WD_W+1)'(wd_q) + (WD_W+1)'(bus.amount);
    assign wd_over   = wd_sum > (WD_W+1)'(WD_LIMIT);

    always_comb begin
        state_d  = state_q;
        pin_d    = pin_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        wd_d     = wd_q;
        bal_d    = bal_q;
        rearm_d  = rearm_q;
        idle_d   = '0;
        end_sess = 1'b0;
        upd_d    = 1'b0;
        disp_d   = 1'b0;
        insuf_d  = 1'b0;
        lim_d    = 1'b0;
        ovf_d    = 1'b0;
        pinw_d   = 1'b0;
        warn_d   = 1'b0;
        tmo_d    = 1'b0;

        if (!bus.card_in) rearm_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.card_in && !rearm_q) begin
                    bal_d   = bus.balance_in;
                    pin_d   = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = S_PIN;
                end
            end
            S_PIN: begin
                if (!bus.card_in) begin
                    end_sess = 1'b1;
                end else if (bus.digit_stb) begin
                    pin_d = PIN_W'({pin_q, bus.digit});
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(PIN_DIGITS - 1)) state_d = S_CHECK;
                end else if (idle_tc && !bus.amount_stb) begin
                    end_sess = 1'b1;
                    tmo_d    = 1'b1;
                    rearm_d  = 1'b1;
                end
            end
            S_CHECK: begin
                if (!bus.card_in) begin
                    end_sess = 1'b1;
                end else if (pin_q == bus.card_pin) begin
                    tries_d = '0;
                    state_d = S_TRANS;
                end else begin
                    pinw_d  = 1'b1;
                    tries_d = tries_inc;
                    pin_d   = '0;
                    cnt_d   = '0;
                    if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        state_d = S_LOCK;
                    end else begin
                        warn_d  = (tries_inc == TRY_W'(MAX_TRIES - 1));
                        state_d = S_PIN;
                    end
                end
            end
            S_TRANS: begin
                if (!bus.card_in) begin
                    end_sess = 1'b1;
                end else if (bus.amount_stb) begin
                    if (!bus.trans_type) begin
                        if (dep_sum[BAL_W]) begin
                            ovf_d = 1'b1;
                        end else begin
                            bal_d = dep_sum[BAL_W-1:0];
                            upd_d = 1'b1;
                        end
                    end else if (amt_ext > bal_q) begin
                        insuf_d = 1'b1;
                    end else if (wd_over) begin
                        lim_d = 1'b1;
                    end else begin
                        bal_d  = bal_q - amt_ext;
                        wd_d   = wd_sum[WD_W-1:0];
                        upd_d  = 1'b1;
                        disp_d = 1'b1;
                    end
                end else if (idle_tc && !bus.digit_stb) begin
                    end_sess = 1'b1;
                    tmo_d    = 1'b1;
                    rearm_d  = 1'b1;
                end
            end
            S_LOCK: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Removal and timeout share the same teardown; balance and tries survive it.
        if (end_sess) begin
            pin_d   = '0;
            cnt_d   = '0;
            wd_d    = '0;
            state_d = S_IDLE;
        end

        if ((state_q == S_PIN || state_q == S_TRANS) && !any_stb && state_d == state_q)
            idle_d = idle_q + 1'b1;

        lock_d = (state_d == S_LOCK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pin_q   <= '0;
            cnt_q   <= '0;
            tries_q <= '0;
            wd_q    <= '0;
            idle_q  <= '0;
            bal_q   <= '0;
            rearm_q <= 1'b0;
            upd_q   <= 1'b0;
            disp_q  <= 1'b0;
            insuf_q <= 1'b0;
            lim_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pinw_q  <= 1'b0;
            warn_q  <= 1'b0;
            lock_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            wd_q    <= wd_d;
            idle_q  <= idle_d;
            bal_q   <= bal_d;
            rearm_q <= rearm_d;
            upd_q   <= upd_d;
            disp_q  <= disp_d;
            insuf_q <= insuf_d;
            lim_q   <= lim_d;
            ovf_q   <= ovf_d;
            pinw_q  <= pinw_d;
            warn_q  <= warn_d;
            lock_q  <= lock_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.balance_out        = bal_q;
    assign bus.balance_updated    = upd_q;
    assign bus.dispense           = disp_q;
    assign bus.insufficient_funds = insuf_q;
    assign bus.limit_exceeded     = lim_q;
    assign bus.deposit_overflow   = ovf_q;
    assign bus.pin_wrong          = pinw_q;
    assign bus.warning            = warn_q;
    assign bus.lock_alarm         = lock_q;
    assign bus.timeout            = tmo_q;
endmodule

// File: tb/tb_atm_ctrl_param.sv
// Bench for atm_ctrl_param: session model feeds a pulse scoreboard; a small-width
// instance covers deposit overflow and mid-transaction reset.
module tb_atm_ctrl_param;
    localparam int PD = 4, DW = 4, BW = 64, AW = 32, MT = 3, WL = 2000, TO = 20;
    localparam logic [15:0] CARD_PIN = 16'h1234;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_s = 1'b0;
    always #5 clk = ~clk;

    atm_ctrl_param_if #(.PIN_DIGITS(PD), .DIG_W(DW), .BAL_W(BW), .AMT_W(AW)) bus ();
    atm_ctrl_param #(.PIN_DIGITS(PD), .DIG_W(DW), .BAL_W(BW), .AMT_W(AW), .MAX_TRIES(MT),
                     .WD_LIMIT(WL), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    atm_ctrl_param_if #(.PIN_DIGITS(PD), .DIG_W(DW), .BAL_W(8), .AMT_W(8)) sbus ();
    atm_ctrl_param #(.PIN_DIGITS(PD), .DIG_W(DW), .BAL_W(8), .AMT_W(8), .MAX_TRIES(MT),
                     .WD_LIMIT(WL), .TIMEOUT(TO)) sdut (.clk(clk), .rst(rst_s), .bus(sbus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [7:0]  pulses;
        logic [63:0] bal;
    } exp_t;
    exp_t sb[$];

    logic [63:0] m_bal;
    logic [63:0] m_wd;
    int          m_tries;

    // pulse vector bits: upd, dispense, insuf, limit, ovf, pin_wrong, warning, timeout
    localparam logic [7:0] P_OK_DEP = 8'h80, P_OK_WD = 8'hC0, P_INSUF = 8'h20, P_LIM = 8'h10;
    localparam logic [7:0] P_OVF = 8'h08, P_PINW = 8'h04, P_WARN = 8'h02, P_TMO = 8'h01;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pulses_now();
        return {bus.balance_updated, bus.dispense, bus.insufficient_funds, bus.limit_exceeded,
                bus.deposit_overflow, bus.pin_wrong, bus.warning, bus.timeout};
    endfunction

    always @(negedge clk) begin
        logic [7:0] p;
        exp_t e;
        p = pulses_now();
        if (p != 8'h00) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", 64'(p), 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_pulses"}, 64'(p), 64'(e.pulses));
                chk({e.tag, "_bal"}, bus.balance_out, e.bal);
            end
        end
    end

    task automatic push(input string tag, input logic [7:0] p);
        exp_t e;
        e.tag = tag;
        e.pulses = p;
        e.bal = m_bal;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit = d;
        bus.digit_stb = 1'b1;
        tick();
        bus.digit_stb = 1'b0;
        tick();
    endtask

    task automatic session(input logic [63:0] bal);
        bus.card_in = 1'b0;
        tick();
        bus.balance_in = bal;
        bus.card_in = 1'b1;
        tick(2);
        m_bal = bal;
        m_wd = '0;
    endtask

    task automatic enter_pin(input string tag, input logic [15:0] v);
        if (v == CARD_PIN) begin
            m_tries = 0;
        end else begin
            m_tries++;
            push(tag, (m_tries == MT - 1) ? (P_PINW | P_WARN) : P_PINW);
        end
        for (int i = 0; i < PD; i++) press(v[15 - 4*i -: 4]);
        tick();
    endtask

    task automatic txn(input string tag, input logic ty, input logic [31:0] amt);
        logic [64:0] s;
        if (!ty) begin
            s = {1'b0, m_bal} + 65'(amt);
            if (s[64]) push(tag, P_OVF);
            else begin
                m_bal = s[63:0];
                push(tag, P_OK_DEP);
            end
        end else if (64'(amt) > m_bal) begin
            push(tag, P_INSUF);
        end else if (m_wd + 64'(amt) > 64'(WL)) begin
            push(tag, P_LIM);
        end else begin
            m_bal = m_bal - 64'(amt);
            m_wd = m_wd + 64'(amt);
            push(tag, P_OK_WD);
        end
        bus.amount = amt;
        bus.trans_type = ty;
        bus.amount_stb = 1'b1;
        tick();
        bus.amount_stb = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk({"drain_", tag}, 64'(sb.size()), 64'd0);
    endtask

    task automatic spress(input logic [3:0] d);
        sbus.digit = d;
        sbus.digit_stb = 1'b1;
        tick();
        sbus.digit_stb = 1'b0;
        tick();
    endtask

    initial begin
        bus.card_in = 0; bus.card_pin = CARD_PIN; bus.balance_in = 0; bus.digit = 0;
        bus.digit_stb = 0; bus.amount = 0; bus.amount_stb = 0; bus.trans_type = 0;
        sbus.card_in = 0; sbus.card_pin = CARD_PIN; sbus.balance_in = 0; sbus.digit = 0;
        sbus.digit_stb = 0; sbus.amount = 0; sbus.amount_stb = 0; sbus.trans_type = 0;
        m_bal = 0; m_wd = 0; m_tries = 0;

        tick(3);
        chk("rst_pulses", 64'(pulses_now()), 64'd0);
        chk("rst_bal", bus.balance_out, 64'd0);
        chk("rst_lock", 64'(bus.lock_alarm), 64'd0);
        rst = 1'b1;
        tick();

        // basic deposit
        session(1000);
        enter_pin("t1_pin", CARD_PIN);
        txn("t1_dep", 1'b0, 100);
        wait_drain("t1");
        chk("t1_bal", bus.balance_out, 64'd1100);

        // withdraw exact balance, then one more
        session(1000);
        enter_pin("t2_pin", CARD_PIN);
        txn("t2_wd_all", 1'b1, 1000);
        txn("t2_wd_insuf", 1'b1, 1);
        wait_drain("t2");
        chk("t2_bal", bus.balance_out, 64'd0);

        // session withdrawal cap
        session(5000);
        enter_pin("t3_pin", CARD_PIN);
        txn("t3_wd1500", 1'b1, 1500);
        txn("t3_wd600", 1'b1, 600);
        txn("t3_wd500", 1'b1, 500);
        txn("t3_wd1", 1'b1, 1);
        txn("t3_wd4000", 1'b1, 4000);
        wait_drain("t3");
        chk("t3_bal", bus.balance_out, 64'd3000);

        // timeout with tries preserved, then removal racing a strobe
        session(800);
        enter_pin("t5_wrong1", 16'h9999);
        push("t5_timeout", P_TMO);
        press(4'd1);
        press(4'd2);
        tick(18);
        @(negedge clk);
        chk("t5_no_early_tmo", 64'(bus.timeout), 64'd0);
        @(negedge clk);
        chk("t5_tmo", 64'(bus.timeout), 64'd1);
        tick(2);
        for (int i = 0; i < PD; i++) press(4'd9);
        tick(3);
        session(800);
        enter_pin("t5_wrong2", 16'h9999);
        enter_pin("t5_pin", CARD_PIN);
        txn("t5_dep", 1'b0, 50);
        bus.card_in = 1'b0;
        bus.amount = 300;
        bus.trans_type = 1'b0;
        bus.amount_stb = 1'b1;
        tick();
        bus.amount_stb = 1'b0;
        tick(2);
        chk("t5_drop_bal", bus.balance_out, m_bal);
        wait_drain("t5");

        // lockout
        session(100);
        enter_pin("t4_try1", 16'h1111);
        enter_pin("t4_try2", 16'h1111);
        enter_pin("t4_try3", 16'h1111);
        chk("t4_lock", 64'(bus.lock_alarm), 64'd1);
        bus.card_in = 1'b0;
        tick();
        bus.card_in = 1'b1;
        tick(2);
        for (int i = 0; i < PD; i++) press(CARD_PIN[15 - 4*i -: 4]);
        bus.amount = 5;
        bus.amount_stb = 1'b1;
        tick();
        bus.amount_stb = 1'b0;
        tick(3);
        chk("t4_lock_held", 64'(bus.lock_alarm), 64'd1);
        chk("t4_lock_bal", bus.balance_out, 64'd100);
        wait_drain("t4_lock");
        rst = 1'b0;
        tick();
        chk("t4_rst_lock", 64'(bus.lock_alarm), 64'd0);
        chk("t4_rst_bal", bus.balance_out, 64'd0);
        chk("t4_rst_pulses", 64'(pulses_now()), 64'd0);
        rst = 1'b1;
        m_tries = 0;
        session(300);
        enter_pin("t4_pin_after_rst", CARD_PIN);
        txn("t4_wd", 1'b1, 100);
        wait_drain("t4");
        chk("t4_bal", bus.balance_out, 64'd200);
        bus.card_in = 1'b0;

        // 8-bit balance: overflow, exact fit, reset mid-TRANS
        rst_s = 1'b1;
        sbus.balance_in = 8'd250;
        sbus.card_in = 1'b1;
        tick(2);
        for (int i = 0; i < PD; i++) spress(CARD_PIN[15 - 4*i -: 4]);
        tick();
        sbus.amount = 8'd10;
        sbus.trans_type = 1'b0;
        sbus.amount_stb = 1'b1;
        tick();
        sbus.amount_stb = 1'b0;
        @(negedge clk);
        chk("t6_ovf", 64'(sbus.deposit_overflow), 64'd1);
        chk("t6_ovf_upd", 64'(sbus.balance_updated), 64'd0);
        chk("t6_ovf_bal", 64'(sbus.balance_out), 64'd250);
        tick();
        sbus.amount = 8'd5;
        sbus.amount_stb = 1'b1;
        tick();
        sbus.amount_stb = 1'b0;
        @(negedge clk);
        chk("t6_fit_upd", 64'(sbus.balance_updated), 64'd1);
        chk("t6_fit_ovf", 64'(sbus.deposit_overflow), 64'd0);
        chk("t6_fit_bal", 64'(sbus.balance_out), 64'd255);
        tick();
        rst_s = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_rst_bal", 64'(sbus.balance_out), 64'd0);
        chk("t6_rst_pulses", 64'({sbus.balance_updated, sbus.dispense, sbus.insufficient_funds,
                                  sbus.limit_exceeded, sbus.deposit_overflow, sbus.pin_wrong,
                                  sbus.warning, sbus.timeout, sbus.lock_alarm}), 64'd0);

        tick(2);
        wait_drain("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
